// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the E stage; owns HI/LO and stalls D-stage HI/LO users.
// Optional accumulate ops (madd/maddu/msub/msubu) are enabled by defining MD_MADD_EN.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] res_hi, res_lo;
  logic        res_ok;

  logic        is_div, op_legal, launch;
  logic signed [63:0] sa, sb, prod_s;
  logic [63:0] prod_u, prod, result;
  logic signed [31:0] sq, sr;
  logic [31:0] uq, ur;

  assign is_div = (md_op[2:1] == 2'b01);
`ifdef MD_MADD_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = ~md_op[2];
`endif
  assign launch = (state == IDLE) & start & op_legal;

  // op bit 0 selects unsigned for every multiply-class op
  always_comb begin
    sa     = {{32{src_a[31]}}, src_a};
    sb     = {{32{src_b[31]}}, src_b};
    prod_s = sa * sb;
    prod_u = {32'b0, src_a} * {32'b0, src_b};
    prod   = md_op[0] ? prod_u : 64'(prod_s);
  end

  // guarded so a zero divisor or the signed overflow case never reaches the divider
  always_comb begin
    sq = '0;
    sr = '0;
    uq = '0;
    ur = '0;
    if (src_b != 32'd0) begin
      uq = src_a / src_b;
      ur = src_a % src_b;
      if (src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
        sq = 32'sh8000_0000;
        sr = '0;
      end else begin
        sq = $signed(src_a) / $signed(src_b);
        sr = $signed(src_a) % $signed(src_b);
      end
    end
  end

  always_comb begin
    result = prod;
    if (is_div)
      result = md_op[0] ? {ur, uq} : {32'(sr), 32'(sq)};
`ifdef MD_MADD_EN
    else if (md_op[2])
      result = md_op[1] ? ({hi, lo} - prod) : ({hi, lo} + prod);
`endif
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (launch) begin
        state_nx = RUN;
        cnt_nx   = is_div ? DC : MC;
      end
      RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_ok <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (launch) begin
        res_hi <= result[63:32];
        res_lo <= result[31:0];
        res_ok <= ~(is_div & (src_b == 32'd0));
      end
      if (state == RUN) begin
        if (cnt == 4'd1 && res_ok) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else if (!start) begin
        if (hi_we) hi <= src_a;
        if (lo_we) lo <= src_a;
      end
    end
  end

  assign busy     = (state == RUN);
  assign md_stall = d_uses_md & (start | busy);
endmodule
